// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline.
// Owns HI/LO, computes the 64-bit result at the accepting edge, then holds busy for a
// fixed number of cycles before committing the pending result to HI/LO.
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (codes 7-10).
module mdu_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;
  localparam logic [3:0] OpLast  = 4'd10;
`else
  localparam logic [3:0] OpLast  = 4'd6;
`endif

  localparam logic [3:0] MulN = MUL_CYCLES[3:0];
  localparam logic [3:0] DivN = DIV_CYCLES[3:0];

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_phi;
  logic [31:0] r_plo;

  state_e      w_state_nxt;
  logic [3:0]  w_cnt_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic [31:0] w_phi_nxt;
  logic [31:0] w_plo_nxt;

  logic        w_legal;
  logic        w_accept;

  // Products: sign- or zero-extend to 64 bits so the low 64 bits of the product are exact.
  logic [63:0] w_a_sx;
  logic [63:0] w_b_sx;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  // Divide: the divisor is forced to 1 whenever the real quotient is not used, so the
  // divider never sees a zero divisor or the INT_MIN / -1 overflow case.
  logic               w_div_zero;
  logic               w_div_ovf;
  logic signed [31:0] w_sa;
  logic signed [31:0] w_sb;
  logic signed [31:0] w_sq;
  logic signed [31:0] w_sr;
  logic [31:0]        w_ub;
  logic [31:0]        w_uq;
  logic [31:0]        w_ur;
  logic [63:0]        w_div_s;
  logic [63:0]        w_div_u;

  assign w_a_sx   = {{32{a[31]}}, a};
  assign w_b_sx   = {{32{b[31]}}, b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  assign w_div_zero = (b == 32'd0);
  assign w_div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign w_sa       = $signed(a);
  assign w_sb       = (w_div_zero || w_div_ovf) ? 32'sd1 : $signed(b);
  assign w_sq       = w_sa / w_sb;
  assign w_sr       = w_sa % w_sb;
  assign w_ub       = w_div_zero ? 32'd1 : b;
  assign w_uq       = a / w_ub;
  assign w_ur       = a % w_ub;

  // Divide by zero keeps the current HI/LO as the pending result so the commit is a no-op.
  assign w_div_s = w_div_zero ? {r_hi, r_lo} :
                   w_div_ovf  ? {32'd0, 32'h8000_0000} :
                                {w_sr, w_sq};
  assign w_div_u = w_div_zero ? {r_hi, r_lo} : {w_ur, w_uq};

`ifdef MDU_MADD_EN
  // Accumulator is HI/LO at the accepting edge; HI/LO cannot change while running.
  logic [63:0] w_acc;
  logic [63:0] w_madd;
  logic [63:0] w_maddu;
  logic [63:0] w_msub;
  logic [63:0] w_msubu;

  assign w_acc   = {r_hi, r_lo};
  assign w_madd  = w_acc + w_prod_s;
  assign w_maddu = w_acc + w_prod_u;
  assign w_msub  = w_acc - w_prod_s;
  assign w_msubu = w_acc - w_prod_u;
`endif

  assign w_legal  = (mdu_op != 4'd0) && (mdu_op <= OpLast);
  assign w_accept = (r_state == StIdle) && start && !flush && w_legal;

  // State and HI/LO registers; reset also drops any pending result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_phi   <= 32'd0;
      r_plo   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_phi   <= w_phi_nxt;
      r_plo   <= w_plo_nxt;
    end
  end

  // Next-state: accept in idle, count down in run, commit on the 1->0 transition.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_phi_nxt   = r_phi;
    w_plo_nxt   = r_plo;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          case (mdu_op)
            OpMthi: w_hi_nxt = a;
            OpMtlo: w_lo_nxt = a;
            OpMult: begin
              {w_phi_nxt, w_plo_nxt} = w_prod_s;
              w_cnt_nxt              = MulN;
            end
            OpMultu: begin
              {w_phi_nxt, w_plo_nxt} = w_prod_u;
              w_cnt_nxt              = MulN;
            end
            OpDiv: begin
              {w_phi_nxt, w_plo_nxt} = w_div_s;
              w_cnt_nxt              = DivN;
            end
            OpDivu: begin
              {w_phi_nxt, w_plo_nxt} = w_div_u;
              w_cnt_nxt              = DivN;
            end
`ifdef MDU_MADD_EN
            OpMadd: begin
              {w_phi_nxt, w_plo_nxt} = w_madd;
              w_cnt_nxt              = MulN;
            end
            OpMaddu: begin
              {w_phi_nxt, w_plo_nxt} = w_maddu;
              w_cnt_nxt              = MulN;
            end
            OpMsub: begin
              {w_phi_nxt, w_plo_nxt} = w_msub;
              w_cnt_nxt              = MulN;
            end
            OpMsubu: begin
              {w_phi_nxt, w_plo_nxt} = w_msubu;
              w_cnt_nxt              = MulN;
            end
`endif
            default: ;
          endcase
          if ((mdu_op != OpMthi) && (mdu_op != OpMtlo)) begin
            w_state_nxt = StRun;
            w_busy_nxt  = 1'b1;
          end
        end
      end
      StRun: begin
        if (flush) begin
          w_state_nxt = StIdle;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt <= 4'd1) begin
          w_state_nxt = StIdle;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_hi_nxt    = r_phi;
          w_lo_nxt    = r_plo;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
